wave_lut_reader: RTL

//  Consumes the waveform start address chosen by the wave-select block and plays that waveform out of the LUT RAM.

---
 rtl/wave_rd_pkg.sv | 20 ++
 rtl/wave_lut_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wave_rd_pkg.sv
// Shared definitions for the waveform LUT reader: FSM encoding and LUT word layout.
package wave_rd_pkg;

  // LUT word layout: [15]=last, [14:8]=repeat, [7:0]=phase
  localparam int unsigned LUT_W    = 16;
  localparam int unsigned LAST_BIT = 15;
  localparam int unsigned RPT_MSB  = 14;
  localparam int unsigned RPT_LSB  = 8;
  localparam int unsigned PH_MSB   = 7;
  localparam int unsigned PH_LSB   = 0;

  // FSM state encoding
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/wave_lut_reader.sv
// Plays a waveform out of the external LUT RAM: walks entries from the selected
// start address until a last-flagged entry, presenting each phase byte as
// repeated frames over valid/ready.
// Optional feature macro WAVE_RD_FRMCNT_EN adds the frm_cnt accepted-frame counter.
module wave_lut_reader
  import wave_rd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned PH_W        = 8,
  parameter int unsigned RPT_W       = 7,
  parameter int unsigned MAX_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              lut_rd,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [LUT_W-1:0]  lut_rdata,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [PH_W-1:0]   frame_data,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef WAVE_RD_FRMCNT_EN
  ,
  output logic [15:0]       frm_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_ENTRIES + 1);

  logic [ST_W-1:0]   state, state_nxt;
  logic [ADDR_W-1:0] lut_addr_nxt;
  logic [CNT_W-1:0]  ent_cnt, ent_cnt_nxt;
  logic [RPT_W-1:0]  rpt_left, rpt_left_nxt;
  logic              last_q, last_nxt;
  logic [PH_W-1:0]   frame_data_nxt;
  logic              lut_rd_nxt, frame_valid_nxt, busy_nxt, done_nxt, err_nxt;
  logic [RPT_W-1:0]  rpt_raw;
  logic              start_acc;
  logic              accept;

  assign rpt_raw   = RPT_W'(lut_rdata[RPT_MSB:RPT_LSB]);
  assign start_acc = (state == ST_IDLE) && start && !abort;
  assign accept    = frame_valid && frame_ready;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lut_addr    <= '0;
      ent_cnt     <= '0;
      rpt_left    <= '0;
      last_q      <= 1'b0;
      frame_data  <= '0;
      lut_rd      <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      lut_addr    <= lut_addr_nxt;
      ent_cnt     <= ent_cnt_nxt;
      rpt_left    <= rpt_left_nxt;
      last_q      <= last_nxt;
      frame_data  <= frame_data_nxt;
      lut_rd      <= lut_rd_nxt;
      frame_valid <= frame_valid_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

  // Next-state, datapath updates and next output values
  always_comb begin
    state_nxt      = state;
    lut_addr_nxt   = lut_addr;
    ent_cnt_nxt    = ent_cnt;
    rpt_left_nxt   = rpt_left;
    last_nxt       = last_q;
    frame_data_nxt = frame_data;
    err_nxt        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_acc) begin
          state_nxt    = ST_FETCH;
          lut_addr_nxt = start_addr;
          ent_cnt_nxt  = '0;
        end
      end
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A zero repeat still shows the entry once
        last_nxt       = lut_rdata[LAST_BIT];
        rpt_left_nxt   = (rpt_raw == '0) ? RPT_W'(1) : rpt_raw;
        frame_data_nxt = PH_W'(lut_rdata[PH_MSB:PH_LSB]);
        state_nxt      = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept) begin
          if (rpt_left == RPT_W'(1)) begin
            if (last_q) begin
              state_nxt = ST_DONE;
            end else if (ent_cnt == CNT_W'(MAX_ENTRIES - 1)) begin
              state_nxt = ST_DONE;
              err_nxt   = 1'b1;
            end else begin
              lut_addr_nxt = lut_addr + ADDR_W'(1);
              ent_cnt_nxt  = ent_cnt + CNT_W'(1);
              state_nxt    = ST_FETCH;
            end
          end else begin
            rpt_left_nxt = rpt_left - RPT_W'(1);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Abort drops playback silently from any active state
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b0;
    end

    lut_rd_nxt      = (state_nxt == ST_FETCH);
    frame_valid_nxt = (state_nxt == ST_HOLD);
    busy_nxt        = (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT) || (state_nxt == ST_HOLD);
    done_nxt        = (state_nxt == ST_DONE);
  end

`ifdef WAVE_RD_FRMCNT_EN
  // Frames accepted since the last accepted start, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt <= '0;
    end else if (start_acc) begin
      frm_cnt <= '0;
    end else if (accept && (frm_cnt != 16'hFFFF)) begin
      frm_cnt <= frm_cnt + 16'd1;
    end
  end
`endif

endmodule
